mesh_input_dispenser: RTL and testbench

Sequenced control block that meters reagent into the inputs of the 2x2 convolving mesh shuffle stage. Each mesh input is fed by an on-chip three-valve peristaltic pump; this block accepts dispense commands (channel, stroke count, phase duration) over a valid/ready handshake. It drives the six-phase valve pattern for the selected pump and reports progress and completion. All other pumps stay sealed.

---
 rtl/mesh_input_dispenser.sv | 180 ++++++++++++++++++
 tb/tb_mesh_input_dispenser.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_input_dispenser.sv
// mesh_input_dispenser: meters reagent into the mesh inputs by sequencing
// the three-valve peristaltic pump of the selected input through a six-phase
// pattern for a commanded number of strokes, then settling with all valves
// closed. Every output comes straight from a flop.
module mesh_input_dispenser #(
    parameter int N_INPUTS = 2,
    parameter int VOL_W    = 8,
    parameter int PHASE_W  = 8,
    localparam int CH_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_W-1:0]       cmd_chan,
    input  logic [VOL_W-1:0]      cmd_strokes,
    input  logic [PHASE_W-1:0]    cmd_phase,
    input  logic                  abort,
    output logic [3*N_INPUTS-1:0] valves,
    output logic                  busy,
    output logic [VOL_W-1:0]      strokes_done,
    output logic                  done,
    output logic                  aborted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PUMP   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Valve pattern {a,b,c} for each pump phase; closed = 1.
    function automatic logic [2:0] phase_pattern(input logic [2:0] ph);
        logic [2:0] pat;
        case (ph)
            3'd0:    pat = 3'b101;
            3'd1:    pat = 3'b100;
            3'd2:    pat = 3'b110;
            3'd3:    pat = 3'b010;
            3'd4:    pat = 3'b011;
            3'd5:    pat = 3'b001;
            default: pat = 3'b111;
        endcase
        return pat;
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            phase_q, phase_d;
    logic [PHASE_W-1:0]    cnt_q, cnt_d;
    logic [PHASE_W-1:0]    plen_q, plen_d;
    logic [VOL_W-1:0]      strokes_q, strokes_d;
    logic [VOL_W-1:0]      sd_q, sd_d;
    logic [CH_W-1:0]       chan_q, chan_d;
    logic [3*N_INPUTS-1:0] valves_q, valves_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  last_cycle_s;
    logic [VOL_W-1:0]      sd_inc_s;

    // Next-state, counters and the registered-output values derived from them.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        plen_d       = plen_q;
        strokes_d    = strokes_q;
        sd_d         = sd_q;
        chan_d       = chan_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        last_cycle_s = (cnt_q == (plen_q - PHASE_W'(1)));
        sd_inc_s     = sd_q + VOL_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    chan_d    = cmd_chan;
                    strokes_d = cmd_strokes;
                    plen_d    = (cmd_phase == PHASE_W'(0)) ? PHASE_W'(1) : cmd_phase;
                    sd_d      = VOL_W'(0);
                    cnt_d     = PHASE_W'(0);
                    phase_d   = 3'd0;
                    state_d   = (cmd_strokes == VOL_W'(0)) ? ST_SETTLE : ST_PUMP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUMP: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (last_cycle_s) begin
                    cnt_d = PHASE_W'(0);
                    if (phase_q == 3'd5) begin
                        phase_d = 3'd0;
                        sd_d    = sd_inc_s;
                        if (sd_inc_s == strokes_q) begin
                            state_d = ST_SETTLE;
                        end else begin
                            state_d = ST_PUMP;
                        end
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + PHASE_W'(1);
                end
            end
            ST_SETTLE: begin
                // Abort takes priority even on the final settle cycle.
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (last_cycle_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = PHASE_W'(0);
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + PHASE_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        valves_d    = '1;
        // An out-of-range channel matches no pump, so everything stays sealed.
        for (int i = 0; i < N_INPUTS; i++) begin
            if ((state_d == ST_PUMP) && (chan_d == CH_W'(i))) begin
                valves_d[3*i +: 3] = phase_pattern(phase_d);
            end else begin
                valves_d[3*i +: 3] = 3'b111;
            end
        end
    end

    // State and output registers; reset seals every valve immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 3'd0;
            cnt_q       <= PHASE_W'(0);
            plen_q      <= PHASE_W'(1);
            strokes_q   <= VOL_W'(0);
            sd_q        <= VOL_W'(0);
            chan_q      <= CH_W'(0);
            valves_q    <= '1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            plen_q      <= plen_d;
            strokes_q   <= strokes_d;
            sd_q        <= sd_d;
            chan_q      <= chan_d;
            valves_q    <= valves_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign valves       = valves_q;
    assign busy         = busy_q;
    assign strokes_done = sd_q;
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_mesh_input_dispenser.sv
// Directed bench for mesh_input_dispenser with a completion scoreboard.
// Time label convention: values observed at the falling edge following
// rising edge k belong to cycle label k+1; an accept on edge t0 shows its
// first pump phase at label t0+1.
module tb_mesh_input_dispenser;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [0:0] cmd_chan;
    logic [7:0] cmd_strokes;
    logic [7:0] cmd_phase;
    logic       abort;
    logic [5:0] valves;
    logic       busy;
    logic [7:0] strokes_done;
    logic       done;
    logic       aborted;

    typedef struct {
        int   label;
        logic kind;   // 0 = done, 1 = aborted
        int   sd;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;
    int   cyc;

    mesh_input_dispenser #(.N_INPUTS(2), .VOL_W(8), .PHASE_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_chan(cmd_chan), .cmd_strokes(cmd_strokes), .cmd_phase(cmd_phase),
        .abort(abort), .valves(valves), .busy(busy),
        .strokes_done(strokes_done), .done(done), .aborted(aborted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] pat(input int ph);
        case (ph)
            0: return 3'b101;
            1: return 3'b100;
            2: return 3'b110;
            3: return 3'b010;
            4: return 3'b011;
            5: return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive a command from a falling edge; returns at label t0+1.
    task automatic send(input int ch, input int s, input int ph, input int abort_at, output int t0);
        exp_t e;
        int   p;
        int   sd_at;
        cmd_chan    = ch[0:0];
        cmd_strokes = s[7:0];
        cmd_phase   = ph[7:0];
        cmd_valid   = 1'b1;
        check("cmd_ready at accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        t0        = cyc;
        cmd_valid = 1'b0;
        p = (ph == 0) ? 1 : ph;
        if (abort_at == 0) begin
            e.label = t0 + 1 + 6 * p * s + p;
            e.kind  = 1'b0;
            e.sd    = s;
        end else begin
            sd_at   = (abort_at - 1) / (6 * p);
            e.label = t0 + abort_at + 1;
            e.kind  = 1'b1;
            e.sd    = (sd_at < s) ? sd_at : s;
        end
        sb_q.push_back(e);
    endtask

    // Wait (bounded) for a done/aborted pulse and score it; stays on that label.
    task automatic wait_result(input string tag, input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (!(done === 1'b1 || aborted === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end else if (sb_q.size() == 0) begin
            check({tag, " unexpected pulse"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, " label"}, cyc + 1, e.label);
            check({tag, " kind"}, {30'd0, aborted, done}, e.kind ? 32'd2 : 32'd1);
            check({tag, " strokes_done"}, {24'd0, strokes_done}, e.sd);
            check({tag, " valves sealed"}, {26'd0, valves}, 32'h3f);
        end
    endtask

    initial begin
        int t0;
        int npulse;
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_chan    = 1'b0;
        cmd_strokes = 8'd0;
        cmd_phase   = 8'd0;
        abort       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst valves", {26'd0, valves}, 32'h3f);
        check("rst busy/done/aborted", {29'd0, busy, done, aborted}, 32'd0);
        check("rst strokes_done", {24'd0, strokes_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready after release", {31'd0, cmd_ready}, 32'd1);

        // Basic: chan 1, 3 strokes, phase 2; commands while busy are ignored
        send(1, 3, 2, 0, t0);
        for (int k = 0; k < 38; k++) begin
            if (k == 5) begin
                cmd_chan = 1'b0; cmd_strokes = 8'd9; cmd_phase = 8'd1; cmd_valid = 1'b1;
            end else if (k == 9) begin
                cmd_valid = 1'b0;
            end
            if (k < 36) begin
                check("basic valves", {26'd0, valves}, {26'd0, pat((k / 2) % 6), 3'b111});
                check("basic strokes_done", {24'd0, strokes_done}, k / 12);
            end else begin
                check("basic settle valves", {26'd0, valves}, 32'h3f);
                check("basic settle strokes_done", {24'd0, strokes_done}, 32'd3);
            end
            check("basic busy/ready", {30'd0, busy, cmd_ready}, 32'd2);
            @(negedge clk);
        end
        wait_result("basic", 10);
        check("basic done ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("basic pulse width", {30'd0, done, aborted}, 32'd0);

        // Zero strokes, zero phase: no valve motion, done at t0+2
        send(0, 0, 0, 0, t0);
        check("s0 valves", {26'd0, valves}, 32'h3f);
        check("s0 busy", {31'd0, busy}, 32'd1);
        wait_result("s0", 5);
        @(negedge clk);

        // One stroke, zero phase: six single-cycle phases, done at t0+8
        send(0, 1, 0, 0, t0);
        for (int k = 0; k < 6; k++) begin
            check("s1 valves", {26'd0, valves}, {29'd7, pat(k)});
            @(negedge clk);
        end
        check("s1 settle valves", {26'd0, valves}, 32'h3f);
        wait_result("s1", 5);

        // Back-to-back: next command accepted in the done cycle
        send(1, 1, 1, 0, t0);
        wait_result("b2b first", 20);
        send(0, 2, 1, 0, t0);
        check("b2b phase0 valves", {26'd0, valves}, 32'h3d);
        check("b2b busy", {31'd0, busy}, 32'd1);
        wait_result("b2b second", 30);
        @(negedge clk);

        // Abort mid-pump: chan 0, 5 strokes, phase 4, abort sampled at t0+30
        send(0, 5, 4, 30, t0);
        repeat (29) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        wait_result("abort", 2);
        npulse = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (done === 1'b1 || aborted === 1'b1) npulse++;
        end
        check("abort no later pulse", npulse, 32'd0);
        check("abort strokes_done frozen", {24'd0, strokes_done}, 32'd1);

        // Abort on the final settle cycle wins over done
        send(1, 0, 3, 3, t0);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_result("abort settle", 2);
        @(negedge clk);
        check("abort settle no done", {30'd0, done, aborted}, 32'd0);

        // Abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle abort", {29'd0, aborted, busy, cmd_ready}, 32'd1);

        // Reset asserted mid-pump
        send(1, 4, 3, 0, t0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst valves async", {26'd0, valves}, 32'h3f);
        check("midrst busy async", {31'd0, busy}, 32'd0);
        sb_q.delete();
        npulse = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done === 1'b1 || aborted === 1'b1 || cmd_ready === 1'b1) npulse++;
        end
        check("midrst held quiet", npulse, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst strokes_done", {24'd0, strokes_done}, 32'd0);
        npulse = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || aborted === 1'b1 || busy === 1'b1) npulse++;
        end
        check("midrst no resume", npulse, 32'd0);

        // Max count: 255 strokes, phase 1, done at t0+1+1530+1
        send(1, 255, 1, 0, t0);
        wait_result("max", 1600);
        @(negedge clk);

        check("scoreboard empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
